// File: rtl/census_pkg.sv
// census_pkg: definitions shared by the census transform and the downstream
// SGBM Hamming-cost stage.
//   ROW_W / COL_W  : width of the row / column coordinate tags
//   tag_t          : row/col tag travelling alongside each pixel or census word
//   census_width() : census word width for a WIN x WIN window (centre excluded)
package census_pkg;

  localparam int ROW_W = 10;
  localparam int COL_W = 10;

  typedef struct packed {
    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] col;
  } tag_t;

  function automatic int census_width(input int win);
    return win * win - 1;
  endfunction

endpackage

// File: rtl/census_line_buf.sv
// census_line_buf: chain of LINES row buffers, each DEPTH pixels deep, sharing
// one address. A write pushes din into line 0 and moves every line's old value
// at that address into the next line, so line j holds the pixel from j+1 rows
// above the row being written. Reads are asynchronous and return the contents
// before the write of the current edge (read-before-write).
// Ports:
//   clk  : rising-edge clock
//   we   : write/shift enable (one pixel accepted)
//   addr : column address
//   din  : incoming pixel, written to line 0
//   dout : old contents of every line at addr, dout[j] = line j
// The RAM is never reset; the census stage masks any stale contents.
module census_line_buf #(
  parameter int PIX_W = 8,
  parameter int DEPTH = 400,
  parameter int LINES = 4,
  parameter int AW    = 9
) (
  input  logic                         clk,
  input  logic                         we,
  input  logic [AW-1:0]                addr,
  input  logic [PIX_W-1:0]             din,
  output logic [LINES-1:0][PIX_W-1:0]  dout
);

  logic [PIX_W-1:0] mem [LINES][DEPTH];

  always_comb begin
    for (int j = 0; j < LINES; j++) begin
      dout[j] = mem[j][addr];
    end
  end

  always_ff @(posedge clk) begin
    if (we) begin
      mem[0][addr] <= din;
      for (int j = 1; j < LINES; j++) begin
        mem[j][addr] <= mem[j-1][addr];
      end
    end
  end

endmodule

// File: rtl/census_win_tf.sv
// census_win_tf: WIN x WIN census transform on a raster pixel stream.
// Each accepted pixel (r,c) completes the window centred on (r-R, c-R); the
// census word for that centre is emitted 3 cycles after the accept, tagged
// with the centre coordinates. Centres in the top/left R-wide band are emitted
// with a zero word; the right/bottom bands are never emitted.
// Ports:
//   clk      : rising-edge clock
//   rst      : synchronous active-low reset
//   en       : pixel accept strobe (no backpressure)
//   in_data  : pixel value
//   row_in   : row of in_data
//   col_in   : column of in_data (raster order)
//   thresh   : noise threshold, only with CENSUS_NOISE_THRESH_EN defined
//   out_data : census word, bit 0 = window (0,0), centre skipped
//   row_out  : centre row
//   col_out  : centre column
//   valid    : one-cycle qualifier for out_data/row_out/col_out
// Optional build macro CENSUS_NOISE_THRESH_EN adds the thresh port; a bit is
// then set when neighbour + thresh < centre (PIX_W+1 bit sum, no saturation).
module census_win_tf
  import census_pkg::*;
#(
  parameter int PIX_W   = 8,
  parameter int FRAME_W = 400,
  parameter int FRAME_H = 300,
  parameter int WIN     = 5
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic [PIX_W-1:0]             in_data,
  input  logic [ROW_W-1:0]             row_in,
  input  logic [COL_W-1:0]             col_in,
`ifdef CENSUS_NOISE_THRESH_EN
  input  logic [PIX_W-1:0]             thresh,
`endif
  output logic [census_width(WIN)-1:0] out_data,
  output logic [ROW_W-1:0]             row_out,
  output logic [COL_W-1:0]             col_out,
  output logic                         valid
);

  localparam int R       = (WIN - 1) / 2;
  localparam int CEN_W   = census_width(WIN);
  localparam int CEN_POS = R * WIN + R;
  localparam int AW      = (FRAME_W > 1) ? $clog2(FRAME_W) : 1;

  localparam logic [ROW_W-1:0] R_ROW  = ROW_W'(R);
  localparam logic [COL_W-1:0] R_COL  = COL_W'(R);
  localparam logic [ROW_W-1:0] R2_ROW = ROW_W'(2 * R);
  localparam logic [COL_W-1:0] R2_COL = COL_W'(2 * R);
  localparam logic [ROW_W-1:0] FH     = ROW_W'(FRAME_H);
  localparam logic [COL_W-1:0] FW     = COL_W'(FRAME_W);

  function automatic logic below(input logic [PIX_W-1:0] nb,
                                 input logic [PIX_W-1:0] cen,
                                 input logic [PIX_W-1:0] th);
    logic [PIX_W:0] sum;
    sum = {1'b0, nb} + {1'b0, th};
    return sum < {1'b0, cen};
  endfunction

  logic [PIX_W-1:0] thr;
`ifdef CENSUS_NOISE_THRESH_EN
  assign thr = thresh;
`else
  assign thr = '0;
`endif

  logic [WIN-2:0][PIX_W-1:0] lb_rd;
  logic [PIX_W-1:0]          win_q [WIN][WIN];
  logic                      emit;
  logic [CEN_W-1:0]          cmp_bits;

  logic             vld_p0, vld_p1, vld_p2;
  logic             mask_p0, mask_p1;
  tag_t             tag_p0, tag_p1, tag_p2;
  logic [CEN_W-1:0] bits_p1, word_p2;

  census_line_buf #(
    .PIX_W (PIX_W),
    .DEPTH (FRAME_W),
    .LINES (WIN - 1),
    .AW    (AW)
  ) u_line_buf (
    .clk  (clk),
    .we   (en),
    .addr (col_in[AW-1:0]),
    .din  (in_data),
    .dout (lb_rd)
  );

  // Out-of-frame coordinates never produce an output.
  assign emit = (row_in >= R_ROW) && (col_in >= R_COL) &&
                (row_in < FH) && (col_in < FW);

  // Stage 0: window shift on accept; rightmost column is the new pixel at the
  // bottom with older rows above it (line j is row r-1-j).
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < WIN; i++) begin
        for (int j = 0; j < WIN; j++) begin
          win_q[i][j] <= '0;
        end
      end
      vld_p0  <= 1'b0;
      mask_p0 <= 1'b0;
      tag_p0  <= '0;
    end else begin
      vld_p0 <= en && emit;
      if (en) begin
        for (int i = 0; i < WIN; i++) begin
          for (int j = 0; j < WIN - 1; j++) begin
            win_q[i][j] <= win_q[i][j+1];
          end
        end
        for (int i = 0; i < WIN - 1; i++) begin
          win_q[i][WIN-1] <= lb_rd[WIN-2-i];
        end
        win_q[WIN-1][WIN-1] <= in_data;
        tag_p0.row <= row_in - R_ROW;
        tag_p0.col <= col_in - R_COL;
        // Centre row/col < R means the window reaches outside the frame.
        mask_p0    <= (row_in < R2_ROW) || (col_in < R2_COL);
      end
    end
  end

  // Raster-ordered compare bits; positions after the centre shift down by one.
  for (genvar gi = 0; gi < WIN; gi++) begin : g_row
    for (genvar gj = 0; gj < WIN; gj++) begin : g_col
      localparam int POS = gi * WIN + gj;
      if (POS < CEN_POS) begin : g_lo
        assign cmp_bits[POS] = below(win_q[gi][gj], win_q[R][R], thr);
      end else if (POS > CEN_POS) begin : g_hi
        assign cmp_bits[POS-1] = below(win_q[gi][gj], win_q[R][R], thr);
      end
    end
  end

  // Stage 1: compare results captured from the window as left by stage 0.
  always_ff @(posedge clk) begin
    if (!rst) begin
      vld_p1  <= 1'b0;
      mask_p1 <= 1'b0;
      tag_p1  <= '0;
    end else begin
      vld_p1  <= vld_p0;
      mask_p1 <= mask_p0;
      tag_p1  <= tag_p0;
    end
  end

  always_ff @(posedge clk) begin
    bits_p1 <= cmp_bits;
    word_p2 <= mask_p1 ? '0 : bits_p1;
  end

  // Stage 2: masked census word (data path above), control follows.
  always_ff @(posedge clk) begin
    if (!rst) begin
      vld_p2 <= 1'b0;
      tag_p2 <= '0;
    end else begin
      vld_p2 <= vld_p1;
      tag_p2 <= tag_p1;
    end
  end

  // Output registers: updated only on a valid result, otherwise held.
  always_ff @(posedge clk) begin
    if (!rst) begin
      out_data <= '0;
      row_out  <= '0;
      col_out  <= '0;
      valid    <= 1'b0;
    end else begin
      valid <= vld_p2;
      if (vld_p2) begin
        out_data <= word_p2;
        row_out  <= tag_p2.row;
        col_out  <= tag_p2.col;
      end
    end
  end

endmodule

// File: tb/tb_census_win_tf.sv
// Bench for census_win_tf: a WIN=3 instance on an 8x8 frame and a WIN=5
// instance on a 16x16 frame, checked cycle by cycle against a reference that
// computes each census word directly from the stored frame image.
module tb_census_win_tf;

  localparam int MAXC = 2000;

  typedef struct {
    logic [31:0] d;
    logic [9:0]  r;
    logic [9:0]  c;
  } rec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en3 = 1'b0, en5 = 1'b0;
  logic [7:0]  d3 = '0, d5 = '0;
  logic [9:0]  r3 = '0, c3 = '0, r5 = '0, c5 = '0;
  logic [7:0]  thresh = '0;
  logic [7:0]  od3;
  logic [23:0] od5;
  logic [9:0]  or3, oc3, or5, oc5;
  logic        v3, v5;

  int n_cmp = 0;
  int n_err = 0;

  int          img [2][16][16];
  logic [31:0] last_d [2];
  logic [9:0]  last_r [2], last_c [2];

  bit          acc_v [MAXC];
  logic [31:0] acc_d [MAXC];
  logic [9:0]  acc_r [MAXC], acc_c [MAXC];
  logic        exp_v [MAXC], obs_v [MAXC];
  logic [31:0] exp_d [MAXC], obs_d [MAXC];
  logic [9:0]  exp_r [MAXC], exp_c [MAXC], obs_r [MAXC], obs_c [MAXC];

  rec_t seq[$];
  rec_t q2[$];

  always #5 clk = ~clk;

  census_win_tf #(.PIX_W(8), .FRAME_W(8), .FRAME_H(8), .WIN(3)) dut3 (
    .clk(clk), .rst(rst), .en(en3), .in_data(d3), .row_in(r3), .col_in(c3),
`ifdef CENSUS_NOISE_THRESH_EN
    .thresh(thresh),
`endif
    .out_data(od3), .row_out(or3), .col_out(oc3), .valid(v3));

  census_win_tf #(.PIX_W(8), .FRAME_W(16), .FRAME_H(16), .WIN(5)) dut5 (
    .clk(clk), .rst(rst), .en(en5), .in_data(d5), .row_in(r5), .col_in(c5),
`ifdef CENSUS_NOISE_THRESH_EN
    .thresh(thresh),
`endif
    .out_data(od5), .row_out(or5), .col_out(oc5), .valid(v5));

  // Census word of centre (cr,cc) straight from the frame image.
  function automatic logic [31:0] ref_census(input int which, input int cr, input int cc);
    int w = which ? 5 : 3;
    int rr = w / 2;
    int k = 0;
    logic [31:0] res = '0;
    if (cr < rr || cc < rr) return '0;
    for (int i = 0; i < w; i++) begin
      for (int j = 0; j < w; j++) begin
        if (!(i == rr && j == rr)) begin
          if (img[which][cr-rr+i][cc-rr+j] + int'(thresh) < img[which][cr][cc]) res[k] = 1'b1;
          k++;
        end
      end
    end
    return res;
  endfunction

  function automatic int pix(input int pattern, input int r, input int c);
    case (pattern)
      0: return 100;
      1: return c;
      2: return r * 16 + c;
      4: return 2 * c;
      default: return int'($urandom_range(0, 255));
    endcase
  endfunction

  // Streams one frame into the selected instance and records expected and
  // observed outputs for every cycle. stop_idx >= 0 applies reset at that pixel
  // and ends the frame there.
  task automatic run_frame(input int which, input int pattern, input int en_pct,
                           input int stop_idx, output int ncyc);
    int fw = which ? 16 : 8;
    int rr = which ? 2 : 1;
    int npix = fw * fw;
    int pi = 0, t = 0, tail = 0, pr, pc, pv;
    bit stopped = 0, busy, e, is_rst;
    while (t < MAXC && tail < 5) begin
      busy = (pi < npix) && !stopped;
      if (!busy) tail++;
      e = busy && (en_pct >= 100 || t >= 1500 || int'($urandom_range(0, 99)) < en_pct);
      pr = pi / fw;
      pc = pi % fw;
      pv = e ? pix(pattern, pr, pc) : int'($urandom_range(0, 255));
      is_rst = e && (pi == stop_idx);
      rst = !is_rst;
      en3 = (which == 0) && e;
      en5 = (which == 1) && e;
      if (which == 0) begin d3 = 8'(pv); r3 = 10'(pr); c3 = 10'(pc); end
      else            begin d5 = 8'(pv); r5 = 10'(pr); c5 = 10'(pc); end
      acc_v[t] = 0;
      if (is_rst) begin
        if (t >= 1) acc_v[t-1] = 0;
        if (t >= 2) acc_v[t-2] = 0;
        for (int w = 0; w < 2; w++) begin
          last_d[w] = '0; last_r[w] = '0; last_c[w] = '0;
        end
        exp_v[t] = 1'b0;
      end else begin
        if (e) begin
          img[which][pr][pc] = pv;
          if (pr >= rr && pc >= rr) begin
            acc_v[t] = 1;
            acc_d[t] = ref_census(which, pr - rr, pc - rr);
            acc_r[t] = 10'(pr - rr);
            acc_c[t] = 10'(pc - rr);
          end
        end
        if (t >= 3 && acc_v[t-3]) begin
          last_d[which] = acc_d[t-3];
          last_r[which] = acc_r[t-3];
          last_c[which] = acc_c[t-3];
          exp_v[t] = 1'b1;
        end else begin
          exp_v[t] = 1'b0;
        end
      end
      exp_d[t] = last_d[which];
      exp_r[t] = last_r[which];
      exp_c[t] = last_c[which];
      @(posedge clk);
      #1;
      obs_v[t] = which ? v5 : v3;
      obs_d[t] = which ? 32'(od5) : 32'(od3);
      obs_r[t] = which ? or5 : or3;
      obs_c[t] = which ? oc5 : oc3;
      if (is_rst) stopped = 1;
      else if (e) pi++;
      t++;
    end
    rst = 1'b1;
    en3 = 1'b0;
    en5 = 1'b0;
    ncyc = t;
  endtask

  task automatic collect_seq(input int n);
    rec_t x;
    seq.delete();
    for (int t = 0; t < n; t++) begin
      if (obs_v[t] === 1'b1) begin
        x.d = obs_d[t]; x.r = obs_r[t]; x.c = obs_c[t];
        seq.push_back(x);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int w = 0; w < 2; w++) begin
      last_d[w] = '0; last_r[w] = '0; last_c[w] = '0;
    end
    n_cmp++; if (v3 !== 1'b0)  begin n_err++; $display("FAIL reset_valid3 got %b want 0", v3); end
    n_cmp++; if (od3 !== 8'h0) begin n_err++; $display("FAIL reset_data3 got %h want 0", od3); end
    n_cmp++; if (or3 !== 10'd0 || oc3 !== 10'd0) begin n_err++; $display("FAIL reset_tag3 got %0d,%0d want 0,0", or3, oc3); end
    n_cmp++; if (v5 !== 1'b0)  begin n_err++; $display("FAIL reset_valid5 got %b want 0", v5); end
    n_cmp++; if (od5 !== 24'h0) begin n_err++; $display("FAIL reset_data5 got %h want 0", od5); end
    n_cmp++; if (or5 !== 10'd0 || oc5 !== 10'd0) begin n_err++; $display("FAIL reset_tag5 got %0d,%0d want 0,0", or5, oc5); end
    rst = 1'b1;
  endtask

  task automatic test_const();
    int n, nv = 0, first = -1;
    run_frame(0, 0, 100, -1, n);
    for (int t = 0; t < n; t++) begin
      n_cmp++;
      if (obs_v[t] !== exp_v[t] || obs_d[t] !== exp_d[t] || obs_r[t] !== exp_r[t] || obs_c[t] !== exp_c[t]) begin
        n_err++;
        $display("FAIL const cyc=%0d got v=%b d=%h r=%0d c=%0d want v=%b d=%h r=%0d c=%0d",
                 t, obs_v[t], obs_d[t], obs_r[t], obs_c[t], exp_v[t], exp_d[t], exp_r[t], exp_c[t]);
      end
      if (obs_v[t] === 1'b1) begin
        nv++;
        if (first < 0) first = t;
      end
    end
    n_cmp++; if (nv != 49) begin n_err++; $display("FAIL const_count got %0d want 49", nv); end
    // Pixel (1,1) is accepted on cycle 9 with en held high.
    n_cmp++; if (first != 12) begin n_err++; $display("FAIL const_first got %0d want 12", first); end
  endtask

  task automatic test_colramp();
    int n;
    bit f33 = 0, f03 = 0, f30 = 0;
    logic [31:0] g33 = '0, g03 = '0, g30 = '0;
    run_frame(0, 1, 100, -1, n);
    for (int t = 0; t < n; t++) begin
      n_cmp++;
      if (obs_v[t] !== exp_v[t] || obs_d[t] !== exp_d[t] || obs_r[t] !== exp_r[t] || obs_c[t] !== exp_c[t]) begin
        n_err++;
        $display("FAIL colramp cyc=%0d got v=%b d=%h r=%0d c=%0d want v=%b d=%h r=%0d c=%0d",
                 t, obs_v[t], obs_d[t], obs_r[t], obs_c[t], exp_v[t], exp_d[t], exp_r[t], exp_c[t]);
      end
      if (obs_v[t] === 1'b1) begin
        if (obs_r[t] == 10'd3 && obs_c[t] == 10'd3) begin f33 = 1; g33 = obs_d[t]; end
        if (obs_r[t] == 10'd0 && obs_c[t] == 10'd3) begin f03 = 1; g03 = obs_d[t]; end
        if (obs_r[t] == 10'd3 && obs_c[t] == 10'd0) begin f30 = 1; g30 = obs_d[t]; end
      end
    end
    n_cmp++; if (!f33 || g33 !== 32'h29) begin n_err++; $display("FAIL colramp_33 got seen=%0d d=%h want 29", f33, g33); end
    n_cmp++; if (!f03 || g03 !== 32'h0) begin n_err++; $display("FAIL colramp_03 got seen=%0d d=%h want 0", f03, g03); end
    n_cmp++; if (!f30 || g30 !== 32'h0) begin n_err++; $display("FAIL colramp_30 got seen=%0d d=%h want 0", f30, g30); end
    collect_seq(n);
    q2 = seq;
  endtask

  task automatic test_ramp5();
    int n, nv = 0;
    bit f44 = 0;
    logic [31:0] g44 = '0;
    run_frame(1, 2, 100, -1, n);
    for (int t = 0; t < n; t++) begin
      n_cmp++;
      if (obs_v[t] !== exp_v[t] || obs_d[t] !== exp_d[t] || obs_r[t] !== exp_r[t] || obs_c[t] !== exp_c[t]) begin
        n_err++;
        $display("FAIL ramp5 cyc=%0d got v=%b d=%h r=%0d c=%0d want v=%b d=%h r=%0d c=%0d",
                 t, obs_v[t], obs_d[t], obs_r[t], obs_c[t], exp_v[t], exp_d[t], exp_r[t], exp_c[t]);
      end
      if (obs_v[t] === 1'b1) begin
        nv++;
        if (obs_r[t] == 10'd4 && obs_c[t] == 10'd4) begin f44 = 1; g44 = obs_d[t]; end
      end
    end
    n_cmp++; if (!f44 || g44 !== 32'h000FFF) begin n_err++; $display("FAIL ramp5_44 got seen=%0d d=%h want 000fff", f44, g44); end
    n_cmp++; if (nv != 196) begin n_err++; $display("FAIL ramp5_count got %0d want 196", nv); end
  endtask

  task automatic test_bubbles();
    int n;
    run_frame(0, 1, 50, -1, n);
    for (int t = 0; t < n; t++) begin
      n_cmp++;
      if (obs_v[t] !== exp_v[t] || obs_d[t] !== exp_d[t] || obs_r[t] !== exp_r[t] || obs_c[t] !== exp_c[t]) begin
        n_err++;
        $display("FAIL bubbles cyc=%0d got v=%b d=%h r=%0d c=%0d want v=%b d=%h r=%0d c=%0d",
                 t, obs_v[t], obs_d[t], obs_r[t], obs_c[t], exp_v[t], exp_d[t], exp_r[t], exp_c[t]);
      end
    end
    collect_seq(n);
    n_cmp++;
    if (seq.size() != q2.size() || q2.size() != 49) begin
      n_err++; $display("FAIL bubbles_len got %0d want %0d (49)", seq.size(), q2.size());
    end else begin
      for (int i = 0; i < q2.size(); i++) begin
        n_cmp++;
        if (seq[i].d !== q2[i].d || seq[i].r !== q2[i].r || seq[i].c !== q2[i].c) begin
          n_err++;
          $display("FAIL bubbles_seq idx=%0d got %h@%0d,%0d want %h@%0d,%0d",
                   i, seq[i].d, seq[i].r, seq[i].c, q2[i].d, q2[i].r, q2[i].c);
        end
      end
    end
  endtask

  task automatic test_midreset();
    int n;
    run_frame(0, 1, 100, 4 * 8 + 2, n);
    for (int t = 0; t < n; t++) begin
      n_cmp++;
      if (obs_v[t] !== exp_v[t] || obs_d[t] !== exp_d[t] || obs_r[t] !== exp_r[t] || obs_c[t] !== exp_c[t]) begin
        n_err++;
        $display("FAIL midreset cyc=%0d got v=%b d=%h r=%0d c=%0d want v=%b d=%h r=%0d c=%0d",
                 t, obs_v[t], obs_d[t], obs_r[t], obs_c[t], exp_v[t], exp_d[t], exp_r[t], exp_c[t]);
      end
    end
    // Cycle 34 is the reset edge: everything must read zero right after it.
    n_cmp++;
    if (obs_v[34] !== 1'b0 || obs_d[34] !== 32'h0 || obs_r[34] !== 10'd0 || obs_c[34] !== 10'd0) begin
      n_err++; $display("FAIL midreset_zero got v=%b d=%h r=%0d c=%0d want all 0", obs_v[34], obs_d[34], obs_r[34], obs_c[34]);
    end
    run_frame(0, 1, 100, -1, n);
    collect_seq(n);
    n_cmp++;
    if (seq.size() != q2.size()) begin
      n_err++; $display("FAIL restart_len got %0d want %0d", seq.size(), q2.size());
    end else begin
      for (int i = 0; i < q2.size(); i++) begin
        n_cmp++;
        if (seq[i].d !== q2[i].d || seq[i].r !== q2[i].r || seq[i].c !== q2[i].c) begin
          n_err++;
          $display("FAIL restart_seq idx=%0d got %h@%0d,%0d want %h@%0d,%0d",
                   i, seq[i].d, seq[i].r, seq[i].c, q2[i].d, q2[i].r, q2[i].c);
        end
      end
    end
  endtask

  task automatic test_random();
    int n;
    run_frame(1, 3, 70, -1, n);
    for (int t = 0; t < n; t++) begin
      n_cmp++;
      if (obs_v[t] !== exp_v[t] || obs_d[t] !== exp_d[t] || obs_r[t] !== exp_r[t] || obs_c[t] !== exp_c[t]) begin
        n_err++;
        $display("FAIL random5 cyc=%0d got v=%b d=%h r=%0d c=%0d want v=%b d=%h r=%0d c=%0d",
                 t, obs_v[t], obs_d[t], obs_r[t], obs_c[t], exp_v[t], exp_d[t], exp_r[t], exp_c[t]);
      end
    end
  endtask

`ifdef CENSUS_NOISE_THRESH_EN
  task automatic test_thresh();
    int n;
    bit f = 0;
    logic [31:0] g = '0;
    thresh = 8'd1;
    run_frame(0, 1, 100, -1, n);
    for (int t = 0; t < n; t++) begin
      n_cmp++;
      if (obs_v[t] !== exp_v[t] || obs_d[t] !== exp_d[t] || obs_r[t] !== exp_r[t] || obs_c[t] !== exp_c[t]) begin
        n_err++;
        $display("FAIL thresh_col cyc=%0d got v=%b d=%h want v=%b d=%h", t, obs_v[t], obs_d[t], exp_v[t], exp_d[t]);
      end
      if (obs_v[t] === 1'b1 && obs_r[t] == 10'd3 && obs_c[t] == 10'd3) begin f = 1; g = obs_d[t]; end
    end
    n_cmp++; if (!f || g !== 32'h0) begin n_err++; $display("FAIL thresh_col_33 got seen=%0d d=%h want 0", f, g); end
    f = 0;
    run_frame(0, 4, 100, -1, n);
    for (int t = 0; t < n; t++) begin
      if (obs_v[t] === 1'b1 && obs_r[t] == 10'd3 && obs_c[t] == 10'd3) begin f = 1; g = obs_d[t]; end
    end
    n_cmp++; if (!f || g !== 32'h29) begin n_err++; $display("FAIL thresh_2col_33 got seen=%0d d=%h want 29", f, g); end
    thresh = 8'd0;
  endtask
`endif

  initial begin
    test_reset();
    test_const();
    test_colramp();
    test_ramp5();
    test_bubbles();
    test_midreset();
    test_random();
`ifdef CENSUS_NOISE_THRESH_EN
    test_thresh();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
